tx_scan_sequencer: RTL and testbench

//  Synthesizable scan scheduler for the transmit path. Steps through focus zones and scan lines and

---
 rtl/tx_seq_pkg.sv | 46 ++++
 rtl/tx_scan_sequencer_timer.sv | 31 +++
 rtl/tx_scan_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_tx_scan_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_seq_pkg.sv
// Shared types, default shot timing and period selection for the transmit scan sequencer.
package tx_seq_pkg;

    localparam int CNT_W = 32;

    localparam int unsigned DEF_NUM_LINES = 128;
    localparam int unsigned DEF_PR_CYC    = 3000;
    localparam int unsigned DEF_RX_CYC    = 250;
    localparam int unsigned DEF_END_CYC   = 80;
    localparam int unsigned DEF_ENV_GAP   = 10;
    localparam int unsigned DEF_ENV_CYC   = 5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PR   = 3'd1,
        ST_RX   = 3'd2,
        ST_WAIT = 3'd3,
        ST_END  = 3'd4,
        ST_GAP  = 3'd5,
        ST_ENV  = 3'd6
    } seq_state_t;

    // Far zones (2/3) use the long period, near zones (0/1) the short one.
    function automatic logic [CNT_W-1:0] select_period(
        input logic [1:0]       focus,
        input logic [CNT_W-1:0] near,
        input logic [CNT_W-1:0] far
    );
        return focus[1] ? far : near;
    endfunction

    // Idle time between rx_gate and end_gate; never shorter than one cycle.
    function automatic logic [CNT_W-1:0] wait_length(
        input logic [CNT_W-1:0] period,
        input logic [CNT_W-1:0] pr_rx
    );
        logic [CNT_W:0] diff;
        diff = {1'b0, period} - {1'b0, pr_rx};
        if (diff[CNT_W] || (diff[CNT_W-1:0] == {CNT_W{1'b0}})) begin
            return {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            return diff[CNT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/tx_scan_sequencer_timer.sv
// Loadable down-counter timing each sequencer phase; done flags the last cycle of a phase.
module tx_phase_timer
    import tx_seq_pkg::*;
(
    input  logic             clk_100M,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_r;

    // Load on phase entry, otherwise count down and rest at zero.
    always_ff @(posedge clk_100M or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign done  = (count_r == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/tx_scan_sequencer.sv
// Transmit scan scheduler: walks focus zones and lines, producing per-shot gate timing.
module tx_scan_sequencer
    import tx_seq_pkg::*;
#(
    parameter int unsigned NUM_LINES = DEF_NUM_LINES,
    parameter int unsigned PR_CYC    = DEF_PR_CYC,
    parameter int unsigned RX_CYC    = DEF_RX_CYC,
    parameter int unsigned END_CYC   = DEF_END_CYC,
    parameter int unsigned ENV_GAP   = DEF_ENV_GAP,
    parameter int unsigned ENV_CYC   = DEF_ENV_CYC
) (
    input  logic        clk_100M,
    input  logic        reset_n,
    input  logic        scan_en,
    input  logic [1:0]  focus_last,
    input  logic [31:0] period_near,
    input  logic [31:0] period_far,
    output logic [7:0]  line_num,
    output logic [1:0]  focus_num,
    output logic        pr_gate,
    output logic        rx_gate,
    output logic        end_gate,
    output logic        envelop,
    output logic        frame_done,
    output logic        busy
);

    localparam logic [7:0]       LINE_MAX  = 8'(NUM_LINES - 1);
    localparam logic [CNT_W-1:0] PR_LEN    = CNT_W'(PR_CYC);
    localparam logic [CNT_W-1:0] RX_LEN    = CNT_W'(RX_CYC);
    localparam logic [CNT_W-1:0] PR_RX_LEN = CNT_W'(PR_CYC + RX_CYC);
    localparam logic [CNT_W-1:0] END_LEN   = CNT_W'(END_CYC);
    localparam logic [CNT_W-1:0] GAP_LEN   = CNT_W'(ENV_GAP);
    localparam logic [CNT_W-1:0] ENV_LEN   = CNT_W'(ENV_CYC);

    seq_state_t       state_r;
    seq_state_t       next_state_s;
    logic             load_s;
    logic [CNT_W-1:0] load_val_s;
    logic             latch_s;
    logic [CNT_W-1:0] count_s;
    logic             done_s;
    logic [CNT_W-1:0] period_r;

    logic             advance_s;
    logic             last_focus_s;
    logic [1:0]       focus_next_s;
    logic [7:0]       line_next_s;
    logic [1:0]       latch_focus_s;
    logic             frame_last_s;
    logic             will_be_one_s;

    logic [7:0]       line_num_r;
    logic [1:0]       focus_num_r;
    logic             pr_gate_r;
    logic             rx_gate_r;
    logic             end_gate_r;
    logic             envelop_r;
    logic             frame_done_r;
    logic             busy_r;

    tx_phase_timer u_timer (
        .clk_100M (clk_100M),
        .reset_n  (reset_n),
        .load     (load_s),
        .load_val (load_val_s),
        .count    (count_s),
        .done     (done_s)
    );

    // Next state and the phase length to load when a new phase begins.
    always_comb begin
        next_state_s = state_r;
        load_s       = 1'b0;
        load_val_s   = {CNT_W{1'b0}};
        latch_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (scan_en) begin
                    next_state_s = ST_PR;
                    load_s       = 1'b1;
                    load_val_s   = PR_LEN;
                    latch_s      = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_PR: begin
                if (done_s) begin
                    next_state_s = ST_RX;
                    load_s       = 1'b1;
                    load_val_s   = RX_LEN;
                end else begin
                    next_state_s = ST_PR;
                end
            end
            ST_RX: begin
                if (done_s) begin
                    next_state_s = ST_WAIT;
                    load_s       = 1'b1;
                    load_val_s   = wait_length(period_r, PR_RX_LEN);
                end else begin
                    next_state_s = ST_RX;
                end
            end
            ST_WAIT: begin
                if (done_s) begin
                    next_state_s = ST_END;
                    load_s       = 1'b1;
                    load_val_s   = END_LEN;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_END: begin
                if (done_s) begin
                    next_state_s = ST_GAP;
                    load_s       = 1'b1;
                    load_val_s   = GAP_LEN;
                end else begin
                    next_state_s = ST_END;
                end
            end
            ST_GAP: begin
                if (done_s) begin
                    next_state_s = ST_ENV;
                    load_s       = 1'b1;
                    load_val_s   = ENV_LEN;
                end else begin
                    next_state_s = ST_GAP;
                end
            end
            ST_ENV: begin
                if (done_s && scan_en) begin
                    next_state_s = ST_PR;
                    load_s       = 1'b1;
                    load_val_s   = PR_LEN;
                    latch_s      = 1'b1;
                end else if (done_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_ENV;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Line/focus stepping; a focus above focus_last counts as the last zone.
    always_comb begin
        advance_s    = (state_r == ST_ENV) && done_s;
        last_focus_s = (focus_num_r >= focus_last);
        if (last_focus_s) begin
            focus_next_s = 2'd0;
            line_next_s  = (line_num_r == LINE_MAX) ? 8'd0 : line_num_r + 8'd1;
        end else begin
            focus_next_s = focus_num_r + 2'd1;
            line_next_s  = line_num_r;
        end
        frame_last_s  = last_focus_s && (line_num_r == LINE_MAX);
        latch_focus_s = (state_r == ST_ENV) ? focus_next_s : focus_num_r;
        will_be_one_s = load_s ? (load_val_s == {{(CNT_W-1){1'b0}}, 1'b1})
                               : (count_s == {{(CNT_W-2){1'b0}}, 2'd2});
    end

    // FSM state, registered gate decode, period latch and scan counters.
    always_ff @(posedge clk_100M or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            period_r     <= {CNT_W{1'b0}};
            line_num_r   <= 8'd0;
            focus_num_r  <= 2'd0;
            pr_gate_r    <= 1'b0;
            rx_gate_r    <= 1'b0;
            end_gate_r   <= 1'b0;
            envelop_r    <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            pr_gate_r    <= (next_state_s == ST_PR);
            rx_gate_r    <= (next_state_s == ST_RX);
            end_gate_r   <= (next_state_s == ST_END);
            envelop_r    <= (next_state_s == ST_ENV);
            busy_r       <= (next_state_s != ST_IDLE);
            frame_done_r <= (next_state_s == ST_ENV) && will_be_one_s && frame_last_s;
            if (latch_s) begin
                period_r <= select_period(latch_focus_s, period_near, period_far);
            end else begin
                period_r <= period_r;
            end
            if (advance_s) begin
                focus_num_r <= focus_next_s;
                line_num_r  <= line_next_s;
            end else begin
                focus_num_r <= focus_num_r;
                line_num_r  <= line_num_r;
            end
        end
    end

    assign line_num   = line_num_r;
    assign focus_num  = focus_num_r;
    assign pr_gate    = pr_gate_r;
    assign rx_gate    = rx_gate_r;
    assign end_gate   = end_gate_r;
    assign envelop    = envelop_r;
    assign frame_done = frame_done_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_tx_scan_sequencer.sv
// Bench for tx_scan_sequencer: shot-timeline reference model compared every cycle, plus literal timing pins.
module tb_tx_scan_sequencer;

    localparam int TB_LINES = 4;

    logic        clk_100M = 1'b0;
    logic        reset_n  = 1'b0;
    logic        scan_en  = 1'b0;
    logic [1:0]  focus_last  = 2'd0;
    logic [31:0] period_near = 32'd12000;
    logic [31:0] period_far  = 32'd29000;
    logic [7:0]  line_num;
    logic [1:0]  focus_num;
    logic        pr_gate, rx_gate, end_gate, envelop, frame_done, busy;

    tx_scan_sequencer #(.NUM_LINES(TB_LINES)) dut (
        .clk_100M    (clk_100M),
        .reset_n     (reset_n),
        .scan_en     (scan_en),
        .focus_last  (focus_last),
        .period_near (period_near),
        .period_far  (period_far),
        .line_num    (line_num),
        .focus_num   (focus_num),
        .pr_gate     (pr_gate),
        .rx_gate     (rx_gate),
        .end_gate    (end_gate),
        .envelop     (envelop),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 clk_100M = ~clk_100M;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // reference model: position inside the current shot
    bit         m_active = 1'b0;
    longint     m_t      = 0;
    longint     m_plen   = 0;
    logic [7:0] m_line   = 8'd0;
    logic [1:0] m_focus  = 2'd0;

    // observation records
    int  n_rise;
    int  pr_rise_cyc[8];
    int  pr_rise_line[8];
    int  pr_rise_focus[8];
    int  pr_hi, rx_hi, end_hi, env_hi;
    int  rx_fall_cyc, end_rise_cyc, end_fall_cyc, env_rise_cyc, env_fall_cyc, busy_fall_cyc;
    int  fd_cnt, fd_in_env, fd_cyc;
    bit  rx_fell_now;
    bit  pr_q = 1'b0, rx_q = 1'b0, end_q = 1'b0, env_q = 1'b0, busy_q = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
        end else begin
            passes++;
        end
    endtask

    function automatic longint wait_len(input longint p);
        return (p <= 3250) ? 64'sd1 : p - 3250;
    endfunction

    function automatic longint shot_len(input longint p);
        return 3000 + 250 + wait_len(p) + 80 + 10 + 5;
    endfunction

    function automatic logic [15:0] model_out();
        logic   pr, rx, en, ev, fd;
        longint sl, e0;
        if (!m_active) return {m_line, m_focus, 6'b000000};
        sl = shot_len(m_plen);
        e0 = 3250 + wait_len(m_plen);
        pr = (m_t < 3000);
        rx = (m_t >= 3000) && (m_t < 3250);
        en = (m_t >= e0) && (m_t < e0 + 80);
        ev = (m_t >= sl - 5);
        fd = (m_t == sl - 1) && (m_line == 8'(TB_LINES - 1)) && (m_focus >= focus_last);
        return {m_line, m_focus, pr, rx, en, ev, fd, 1'b1};
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_t      = 0;
        m_line   = 8'd0;
        m_focus  = 2'd0;
    endtask

    task automatic model_edge();
        if (!reset_n) begin
            model_reset();
        end else if (m_active) begin
            m_t++;
            if (m_t == shot_len(m_plen)) begin
                if (m_focus >= focus_last) begin
                    m_focus = 2'd0;
                    m_line  = 8'((int'(m_line) + 1) % TB_LINES);
                end else begin
                    m_focus = m_focus + 2'd1;
                end
                if (scan_en) begin
                    m_t    = 0;
                    m_plen = m_focus[1] ? longint'(period_far) : longint'(period_near);
                end else begin
                    m_active = 1'b0;
                end
            end
        end else if (scan_en) begin
            m_active = 1'b1;
            m_t      = 0;
            m_plen   = m_focus[1] ? longint'(period_far) : longint'(period_near);
        end
    endtask

    task automatic clear_track();
        n_rise = 0;
        pr_hi = 0; rx_hi = 0; end_hi = 0; env_hi = 0;
        rx_fall_cyc = 0; end_rise_cyc = 0; end_fall_cyc = 0;
        env_rise_cyc = 0; env_fall_cyc = 0; busy_fall_cyc = 0;
        fd_cnt = 0; fd_in_env = 0; fd_cyc = 0;
    endtask

    task automatic step();
        logic [15:0] got;
        @(posedge clk_100M);
        model_edge();
        #1;
        cyc++;
        got = {line_num, focus_num, pr_gate, rx_gate, end_gate, envelop, frame_done, busy};
        chk("outputs", 64'(got), 64'(model_out()));
        rx_fell_now = 1'b0;
        if (pr_gate && !pr_q && n_rise < 8) begin
            pr_rise_cyc[n_rise]   = cyc;
            pr_rise_line[n_rise]  = int'(line_num);
            pr_rise_focus[n_rise] = int'(focus_num);
            n_rise++;
        end
        if (!rx_gate && rx_q) begin rx_fall_cyc = cyc; rx_fell_now = 1'b1; end
        if (end_gate && !end_q) end_rise_cyc = cyc;
        if (!end_gate && end_q) end_fall_cyc = cyc;
        if (envelop && !env_q)  env_rise_cyc = cyc;
        if (!envelop && env_q)  env_fall_cyc = cyc;
        if (!busy && busy_q)    busy_fall_cyc = cyc;
        if (n_rise <= 1) begin
            pr_hi  += int'(pr_gate);
            rx_hi  += int'(rx_gate);
            end_hi += int'(end_gate);
            env_hi += int'(envelop);
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
            if (envelop) fd_in_env++;
        end
        pr_q = pr_gate; rx_q = rx_gate; end_q = end_gate; env_q = envelop; busy_q = busy;
    endtask

    task automatic wait_rises(input int n, input int budget);
        int k = 0;
        while (n_rise < n && k < budget) begin
            step();
            k++;
        end
        chk("pr_rise_timeout", 64'(n_rise >= n), 64'd1);
    endtask

    // Assert reset between edges, confirm outputs clear without a clock, then release.
    task automatic async_reset(input string name);
        #2;
        reset_n = 1'b0;
        #1;
        chk(name, 64'({line_num, focus_num, pr_gate, rx_gate, end_gate, envelop, frame_done, busy}), 64'd0);
        model_reset();
        step();
        step();
        #2;
        reset_n = 1'b1;
    endtask

    function automatic logic [31:0] rnd_period();
        return ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3400)) : 32'($urandom_range(3251, 4500));
    endfunction

    initial begin
        int k;
        clear_track();

        // reset held with scan_en high
        scan_en = 1'b1;
        step(); step(); step();
        chk("rst_pr",    64'(pr_gate),    64'd0);
        chk("rst_rx",    64'(rx_gate),    64'd0);
        chk("rst_end",   64'(end_gate),   64'd0);
        chk("rst_env",   64'(envelop),    64'd0);
        chk("rst_fd",    64'(frame_done), 64'd0);
        chk("rst_busy",  64'(busy),       64'd0);
        chk("rst_line",  64'(line_num),   64'd0);
        chk("rst_focus", 64'(focus_num),  64'd0);

        // single-focus shot at the default near period
        focus_last = 2'd0; period_near = 32'd12000; period_far = 32'd29000;
        #2 reset_n = 1'b1;
        clear_track();
        wait_rises(2, 30000);
        chk("t2_shot_len",  64'(pr_rise_cyc[1] - pr_rise_cyc[0]), 64'd12095);
        chk("t2_pr_len",    64'(pr_hi),  64'd3000);
        chk("t2_rx_len",    64'(rx_hi),  64'd250);
        chk("t2_end_len",   64'(end_hi), 64'd80);
        chk("t2_env_len",   64'(env_hi), 64'd5);
        chk("t2_wait_len",  64'(end_rise_cyc - rx_fall_cyc), 64'd8750);
        chk("t2_gap_len",   64'(env_rise_cyc - end_fall_cyc), 64'd10);
        chk("t2_line0",     64'(pr_rise_line[0]), 64'd0);
        chk("t2_line1",     64'(pr_rise_line[1]), 64'd1);
        async_reset("t2_reset");

        // four focus zones, near/far period selection
        focus_last = 2'd3; period_near = 32'd4000; period_far = 32'd6000;
        clear_track();
        wait_rises(5, 30000);
        chk("t3_len0", 64'(pr_rise_cyc[1] - pr_rise_cyc[0]), 64'd4095);
        chk("t3_len1", 64'(pr_rise_cyc[2] - pr_rise_cyc[1]), 64'd4095);
        chk("t3_len2", 64'(pr_rise_cyc[3] - pr_rise_cyc[2]), 64'd6095);
        chk("t3_len3", 64'(pr_rise_cyc[4] - pr_rise_cyc[3]), 64'd6095);
        for (int i = 0; i < 4; i++) begin
            chk("t3_focus", 64'(pr_rise_focus[i]), 64'(i));
            chk("t3_line",  64'(pr_rise_line[i]),  64'd0);
        end
        chk("t3_line_next", 64'(pr_rise_line[4]), 64'd1);
        async_reset("t3_reset");

        // frame wrap with four lines
        focus_last = 2'd0; period_near = 32'd3300;
        clear_track();
        wait_rises(5, 20000);
        for (int i = 0; i < 5; i++) chk("t4_line", 64'(pr_rise_line[i]), 64'(i % 4));
        chk("t4_fd_count",   64'(fd_cnt),    64'd1);
        chk("t4_fd_in_env",  64'(fd_in_env), 64'd1);
        chk("t4_fd_last_env", 64'(fd_cyc),   64'(pr_rise_cyc[4] - 1));

        // scan_en dropped during rx_gate: shot completes, then idle
        clear_track();
        k = 0;
        while (!rx_gate && k < 5000) begin step(); k++; end
        chk("t5_rx_seen", 64'(rx_gate), 64'd1);
        scan_en = 1'b0;
        k = 0;
        while (busy && k < 5000) begin step(); k++; end
        chk("t5_idle",      64'(busy),      64'd0);
        chk("t5_line",      64'(line_num),  64'd1);
        chk("t5_env_len",   64'(env_fall_cyc - env_rise_cyc), 64'd5);
        chk("t5_busy_fall", 64'(busy_fall_cyc), 64'(env_fall_cyc));

        // short period: one-cycle WAIT, then asynchronous resets
        period_near = 32'd1000; scan_en = 1'b1;
        clear_track();
        wait_rises(2, 10000);
        chk("t6_shot_len", 64'(pr_rise_cyc[1] - pr_rise_cyc[0]), 64'd3346);
        chk("t6_wait_len", 64'(end_rise_cyc - rx_fall_cyc), 64'd1);
        k = 0;
        rx_fell_now = 1'b0;
        while (!rx_fell_now && k < 5000) begin step(); k++; end
        chk("t6_in_wait", 64'({busy, line_num}), 64'({1'b1, 8'd2}));
        async_reset("t6_reset_wait");
        clear_track();
        wait_rises(1, 100);
        chk("t6_restart_line", 64'(pr_rise_line[0]), 64'd0);
        for (int i = 0; i < 100; i++) step();
        async_reset("t6_reset_pr");

        // randomized periods, focus depth and scan_en toggling
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 199) == 0) period_near = rnd_period();
            if ($urandom_range(0, 199) == 0) period_far  = rnd_period();
            if ($urandom_range(0, 2999) == 0) scan_en = ~scan_en;
            if (!m_active && $urandom_range(0, 9) == 0) focus_last = 2'($urandom_range(0, 3));
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
